decryption_router: RTL and testbench

DECRYPTION_ROUTER -- requirements
Module: decryption_router

---
 rtl/decryption_router_pkg.sv | 21 ++
 rtl/decryption_router_fifo.sv | 59 +++++
 rtl/decryption_router.sv | 155 +++++++++++++++
 tb/tb_decryption_router.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/decryption_router_pkg.sv
// Shared definitions for the decryption router slice:
// target encodings, default end-of-message token and pop-side FSM states.
package decryption_router_pkg;

    localparam logic [1:0] SEL_CAESAR  = 2'd0;
    localparam logic [1:0] SEL_SCYTALE = 2'd1;
    localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
    localparam logic [1:0] SEL_INVALID = 2'd3;

    localparam logic [7:0] DEFAULT_TOKEN = 8'hFA;

    // Cycles spent in WAIT_HI without target busy before giving up
    localparam int TIMEOUT_CYCLES = 4;

    typedef enum logic [1:0] {
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

endpackage

// File: rtl/decryption_router_fifo.sv
// Synchronous FIFO with occupancy count; pushes on a full FIFO are
// discarded, pops on an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; stale contents are harmless once pointers reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/decryption_router.sv
// Buffers tagged characters and routes them to one of three decryptors,
// pausing after each end-of-message token until the target reacts.
module decryption_router
    import decryption_router_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN =
        D_WIDTH'(DEFAULT_TOKEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    input  logic [1:0]         select,
    input  logic               busy0_i,
    input  logic               busy1_i,
    input  logic               busy2_i,
    output logic [D_WIDTH-1:0] data0_o,
    output logic [D_WIDTH-1:0] data1_o,
    output logic [D_WIDTH-1:0] data2_o,
    output logic               valid0_o,
    output logic               valid1_o,
    output logic               valid2_o,
    output logic               busy_o,
    output logic               drop_o
);

    localparam int EW = D_WIDTH + 2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] HI_CNT = CW'(FIFO_DEPTH - 1);
    localparam logic [1:0] TMO_LAST = 2'(TIMEOUT_CYCLES - 1);

    logic [EW-1:0]      head;
    logic [1:0]         head_sel;
    logic [D_WIDTH-1:0] head_data;
    logic               full, empty;
    logic [CW-1:0]      count;
    logic               push, pop;
    logic [3:0]         busy_vec;

    state_t state_q, state_d;
    logic [1:0] tgt_q, tgt_d;
    logic [1:0] tmo_q, tmo_d;
    logic [2:0] valid_q, valid_d;
    logic [2:0][D_WIDTH-1:0] data_q, data_d;
    logic drop_q, drop_d;

    assign head_sel  = head[EW-1 -: 2];
    assign head_data = head[D_WIDTH-1:0];
    assign busy_vec  = {1'b0, busy2_i, busy1_i, busy0_i};

    assign push   = valid_i && (select != SEL_INVALID);
    assign drop_d = valid_i && ((select == SEL_INVALID) || full);

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({select, data_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Pop-side FSM: deliver head when its target is idle, hold after tokens
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        unique case (state_q)
            SEND: begin
                if (!empty && !busy_vec[head_sel]) begin
                    pop = 1'b1;
                    if (head_data == START_DECRYPTION_TOKEN) begin
                        state_d = WAIT_HI;
                        tgt_d   = head_sel;
                        tmo_d   = '0;
                    end
                end
            end
            WAIT_HI: begin
                if (busy_vec[tgt_q]) begin
                    state_d = WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = SEND;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!busy_vec[tgt_q]) state_d = SEND;
            end
            default: state_d = SEND;
        endcase
    end

    // Output demux: only the popped entry's target sees data and a strobe
    always_comb begin
        valid_d = '0;
        data_d  = '0;
        if (pop) begin
            unique case (head_sel)
                SEL_CAESAR: begin
                    valid_d[0] = 1'b1;
                    data_d[0]  = head_data;
                end
                SEL_SCYTALE: begin
                    valid_d[1] = 1'b1;
                    data_d[1]  = head_data;
                end
                SEL_ZIGZAG: begin
                    valid_d[2] = 1'b1;
                    data_d[2]  = head_data;
                end
                default: ;
            endcase
        end
    end

    // State, timeout and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEND;
            tgt_q   <= '0;
            tmo_q   <= '0;
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign valid0_o = valid_q[0];
    assign valid1_o = valid_q[1];
    assign valid2_o = valid_q[2];
    assign data0_o  = data_q[0];
    assign data1_o  = data_q[1];
    assign data2_o  = data_q[2];
    assign drop_o   = drop_q;
    assign busy_o   = (count >= HI_CNT);

endmodule

// File: tb/tb_decryption_router.sv
// Scoreboard bench for decryption_router: stimulus queues expected
// {target, char} entries, a negedge monitor pops and compares deliveries.
module tb_decryption_router;
    import decryption_router_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic [1:0] select;
    logic       busy0_i, busy1_i, busy2_i;
    logic [7:0] data0_o, data1_o, data2_o;
    logic       valid0_o, valid1_o, valid2_o;
    logic       busy_o, drop_o;

    always #5 clk = ~clk;

    decryption_router #(
        .D_WIDTH (8),
        .FIFO_DEPTH (16),
        .START_DECRYPTION_TOKEN (8'hFA)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .select   (select),
        .busy0_i  (busy0_i),
        .busy1_i  (busy1_i),
        .busy2_i  (busy2_i),
        .data0_o  (data0_o),
        .data1_o  (data1_o),
        .data2_o  (data2_o),
        .valid0_o (valid0_o),
        .valid1_o (valid1_o),
        .valid2_o (valid2_o),
        .busy_o   (busy_o),
        .drop_o   (drop_o)
    );

    int cyc = 0;
    int checks = 0;
    int fails = 0;
    int n_deliv = 0;
    logic [9:0] exp_q[$];
    int dcyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor: one-hot strobes, idle data zero, in-order scoreboard
    always @(negedge clk) begin : mon
        int nv;
        logic [1:0] t;
        logic [7:0] d;
        logic [7:0] stray;
        logic [9:0] e;
        nv = int'(valid0_o) + int'(valid1_o) + int'(valid2_o);
        stray = (valid0_o ? 8'h00 : data0_o) |
                (valid1_o ? 8'h00 : data1_o) |
                (valid2_o ? 8'h00 : data2_o);
        check("idle_data_zero", 32'(stray), 32'd0);
        if (nv > 1) begin
            check("onehot_valid", nv, 1);
        end else if (nv == 1) begin
            t = valid0_o ? 2'd0 : (valid1_o ? 2'd1 : 2'd2);
            d = valid0_o ? data0_o : (valid1_o ? data1_o : data2_o);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_delivery: got target %0d char %0h, expected none (cycle %0d)",
                         t, d, cyc);
            end else begin
                e = exp_q.pop_front();
                check("deliv_target", 32'(t), 32'(e[9:8]));
                check("deliv_data", 32'(d), 32'(e[7:0]));
            end
            dcyc_q.push_back(cyc);
            n_deliv++;
        end
    end

    task automatic wait_deliv(int n, int budget, string name);
        int k;
        k = 0;
        while (n_deliv < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(name, n_deliv, n);
        @(negedge clk);
    endtask

    // Drive one input at a negedge and optionally expect it delivered
    task automatic drive(logic [1:0] s, logic [7:0] d, bit accept);
        select  = s;
        data_i  = d;
        valid_i = 1'b1;
        if (accept) exp_q.push_back({s, d});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int c0, base;
        logic [7:0] msg [4];
        msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43; msg[3] = 8'hFA;
        rst_n = 1'b0; valid_i = 1'b0; select = 2'd0; data_i = 8'h00;
        busy0_i = 1'b0; busy1_i = 1'b0; busy2_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'({valid2_o, valid1_o, valid0_o}), 32'd0);
        check("rst_data", 32'({data2_o, data1_o, data0_o}), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_drop", 32'(drop_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zigzag message, then X to caesar held behind the token handshake
        dcyc_q.delete();
        base = n_deliv;
        c0 = cyc;
        for (int i = 0; i < 4; i++) drive(SEL_ZIGZAG, msg[i], 1'b1);
        valid_i = 1'b0;
        while (cyc < c0 + 6) @(negedge clk);
        drive(SEL_CAESAR, 8'h58, 1'b1);
        valid_i = 1'b0;
        busy2_i = 1'b1;
        while (cyc < c0 + 13) @(negedge clk);
        busy2_i = 1'b0;
        wait_deliv(base + 5, 60, "zz_count");
        for (int k = 0; k < 4; k++) check("zz_latency", dcyc_q[k] - c0, k + 2);
        check("x_after_busy", 32'(dcyc_q[4] >= c0 + 14), 32'd1);
        repeat (8) @(negedge clk);

        // Invalid select is dropped, never delivered
        drive(SEL_INVALID, 8'h41, 1'b0);
        valid_i = 1'b0;
        check("inv_drop", 32'(drop_o), 32'd1);
        @(negedge clk);
        check("inv_drop_clr", 32'(drop_o), 32'd0);
        repeat (6) @(negedge clk);

        // Fill with scytale target busy, overflow, then drain in order
        busy1_i = 1'b1;
        base = n_deliv;
        for (int i = 0; i < 17; i++) begin
            drive(SEL_SCYTALE, 8'(8'h30 + i), i < 16);
            if (i == 13) check("busy_o_cnt14", 32'(busy_o), 32'd0);
            if (i == 14) check("busy_o_cnt15", 32'(busy_o), 32'd1);
            if (i == 15) check("no_drop_16th", 32'(drop_o), 32'd0);
            if (i == 16) check("drop_17th", 32'(drop_o), 32'd1);
        end
        valid_i = 1'b0;
        check("held_no_deliv", n_deliv - base, 0);
        busy1_i = 1'b0;
        wait_deliv(base + 16, 100, "fill_drain_count");
        check("busy_o_drained", 32'(busy_o), 32'd0);
        repeat (4) @(negedge clk);

        // Token to caesar with no busy response: timeout then next char
        dcyc_q.delete();
        base = n_deliv;
        drive(SEL_CAESAR, 8'hFA, 1'b1);
        drive(SEL_CAESAR, 8'h51, 1'b1);
        valid_i = 1'b0;
        wait_deliv(base + 2, 40, "tmo_count");
        check("tmo_gap", dcyc_q[1] - dcyc_q[0], 5);
        repeat (4) @(negedge clk);

        // Reset with queued entries discards them all
        busy0_i = 1'b1;
        base = n_deliv;
        for (int i = 0; i < 5; i++) drive(SEL_CAESAR, 8'(8'h60 + i), 1'b1);
        valid_i = 1'b0;
        @(negedge clk);
        check("queued_busy_o", 32'(busy_o), 32'd0);
        rst_n = 1'b0;
        drive(SEL_CAESAR, 8'h77, 1'b0);
        exp_q.delete();
        check("mid_rst_valid", 32'({valid2_o, valid1_o, valid0_o}), 32'd0);
        check("mid_rst_data", 32'({data2_o, data1_o, data0_o}), 32'd0);
        check("mid_rst_drop", 32'(drop_o), 32'd0);
        rst_n = 1'b1;
        valid_i = 1'b0;
        busy0_i = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_deliv", n_deliv - base, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
